// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer slice: opcodes, instruction field
// positions and the sequencer state encoding.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    localparam int FIELD_W = 3;
    localparam int OP_LSB  = 13;
    localparam int RD_LSB  = 10;
    localparam int RA_LSB  = 7;
    localparam int RB_LSB  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        WRITE   = 2'd3
    } state_t;

    // Only add and sub produce a meaningful carry; every other op clears it.
    function automatic logic op_has_carry(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake, ALU operand/result bus and architectural status
// grouped into one interface; slave = sequencer, master = parent/source.
interface alu_sequencer_if #(
    parameter int DATA_W  = 8,
    parameter int INSTR_W = 16
);
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  alu_a;
    logic [DATA_W-1:0]  alu_b;
    logic [2:0]         alu_opcode;
    logic [DATA_W-1:0]  alu_out;
    logic               alu_zero;
    logic               alu_carry;
    logic               flag_z;
    logic               flag_c;
    logic               done;

    modport slave (
        input  instr_valid, instr, alu_out, alu_zero, alu_carry,
        output instr_ready, alu_a, alu_b, alu_opcode, flag_z, flag_c, done
    );

    modport master (
        output instr_valid, instr, alu_out, alu_zero, alu_carry,
        input  instr_ready, alu_a, alu_b, alu_opcode, flag_z, flag_c, done
    );
endinterface

// File: rtl/alu.sv
// Combinational 8-bit ALU driven by the sequencer; carry is only meaningful
// for add (carry out) and sub (borrow).
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        opcode,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry
);
    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (opcode)
            OP_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
            OP_SUB:  {carry, result} = {1'b0, a} - {1'b0, b};
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            OP_SHL:  result = a << 1;
            OP_SHR:  result = a >> 1;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);
endmodule

// File: rtl/alu_regfile.sv
// NREG x DATA_W register file: two async read ports, one sync write port,
// async clear. ALU_SEQ_DBG_EN adds a third async read port for debug.
module alu_regfile #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [AW-1:0]     rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd
`ifdef ALU_SEQ_DBG_EN
    ,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
`endif
);
    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    // Reads are combinational so a write lands before the next IDLE-cycle read.
    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];

`ifdef ALU_SEQ_DBG_EN
    assign dbg_data = regs[dbg_addr];
`endif
endmodule

// File: rtl/alu_sequencer.sv
// Four-state execution controller (IDLE/ISSUE/CAPTURE/WRITE) feeding an external
// combinational ALU. ALU_SEQ_DBG_EN exposes a debug register read port.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NREG    = 8,
    parameter int INSTR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_sequencer_if.slave    bus
`ifdef ALU_SEQ_DBG_EN
    ,
    input  logic [FIELD_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
`endif
);
    state_t               state_reg, state_next;
    logic [INSTR_W-1:0]   instr_w;
    logic [FIELD_W-1:0]   op_f, rd_f, ra_f, rb_f;
    logic [FIELD_W-1:0]   rd_reg;
    logic [2:0]           op_reg;
    logic [DATA_W-1:0]    alu_a_reg, alu_b_reg, res_reg;
    logic [DATA_W-1:0]    rf_a, rf_b;
    logic                 zero_reg, carry_reg;
    logic                 flag_z_reg, flag_c_reg, done_reg;
    logic                 accept, rf_we;
    logic                 unused_reserved;

    assign instr_w         = bus.instr;
    assign op_f            = instr_w[OP_LSB +: FIELD_W];
    assign rd_f            = instr_w[RD_LSB +: FIELD_W];
    assign ra_f            = instr_w[RA_LSB +: FIELD_W];
    assign rb_f            = instr_w[RB_LSB +: FIELD_W];
    assign unused_reserved = ^instr_w[RB_LSB-1:0];

    assign accept = (state_reg == IDLE) && bus.instr_valid;
    assign rf_we  = (state_reg == WRITE);

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .AW     (FIELD_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (ra_f),
        .ra_data  (rf_a),
        .rb_addr  (rb_f),
        .rb_data  (rf_b),
        .we       (rf_we),
        .wa       (rd_reg),
        .wd       (res_reg)
`ifdef ALU_SEQ_DBG_EN
        ,
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.instr_valid) state_next = ISSUE;
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_reg  <= '0;
            alu_b_reg  <= '0;
            op_reg     <= '0;
            rd_reg     <= '0;
            res_reg    <= '0;
            zero_reg   <= 1'b0;
            carry_reg  <= 1'b0;
            flag_z_reg <= 1'b0;
            flag_c_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Operands are sampled at accept, so rd may alias ra/rb freely.
                    if (accept) begin
                        alu_a_reg <= rf_a;
                        alu_b_reg <= rf_b;
                        op_reg    <= op_f;
                        rd_reg    <= rd_f;
                    end
                end
                CAPTURE: begin
                    res_reg   <= bus.alu_out;
                    zero_reg  <= bus.alu_zero;
                    carry_reg <= bus.alu_carry;
                end
                WRITE: begin
                    flag_z_reg <= zero_reg;
                    flag_c_reg <= op_has_carry(op_reg) & carry_reg;
                    done_reg   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.instr_ready = (state_reg == IDLE);
    assign bus.alu_a       = alu_a_reg;
    assign bus.alu_b       = alu_b_reg;
    assign bus.alu_opcode  = op_reg;
    assign bus.flag_z      = flag_z_reg;
    assign bus.flag_c      = flag_c_reg;
    assign bus.done        = done_reg;
endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a real ALU attached; a scoreboard
// predicts operands at accept and flags at done.
`timescale 1ns/1ps
module tb_alu_sequencer;
    import alu_pkg::*;

    typedef struct {
        logic [2:0] op;
        logic [2:0] rd;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       z;
        logic       c;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_sequencer_if #(.DATA_W(8), .INSTR_W(16)) bus ();

`ifdef ALU_SEQ_DBG_EN
    logic [2:0] dbg_addr = 3'd0;
    logic [7:0] dbg_data;
`endif

    alu #(.DATA_W(8)) u_alu (
        .a      (bus.alu_a),
        .b      (bus.alu_b),
        .opcode (bus.alu_opcode),
        .result (bus.alu_out),
        .zero   (bus.alu_zero),
        .carry  (bus.alu_carry)
    );

    alu_sequencer #(.DATA_W(8), .NREG(8), .INSTR_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef ALU_SEQ_DBG_EN
        ,
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
`endif
    );

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] model_r [8];
    int         n_vec = 0;
    int         n_err = 0;
    logic       acc_seen = 1'b0;

    function automatic exp_t predict(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   s;
        e.op = op; e.rd = rd; e.a = a; e.b = b; e.c = 1'b0; e.res = 8'h00;
        case (op)
            OP_ADD: begin s = int'(a) + int'(b); e.res = s[7:0]; e.c = (s > 255); end
            OP_SUB: begin e.res = a - b; e.c = (a < b); end
            OP_AND: e.res = a & b;
            OP_OR:  e.res = a | b;
            OP_XOR: e.res = a ^ b;
            OP_NOT: e.res = ~a;
            OP_SHL: e.res = {a[6:0], 1'b0};
            default: e.res = {1'b0, a[7:1]};
        endcase
        e.z = (e.res == 8'h00);
        return e;
    endfunction

    // Scoreboard monitor: operands checked in ISSUE, flags checked on done.
    always @(posedge clk) acc_seen <= rst_n && bus.instr_valid && bus.instr_ready;

    always @(negedge clk) begin
        if (rst_n && acc_seen) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL issue_operands: accept with empty scoreboard");
            end else if ({bus.alu_a, bus.alu_b, bus.alu_opcode} !== {sb[$].a, sb[$].b, sb[$].op}) begin
                n_err++;
                $display("FAIL issue_operands: got a=%h b=%h op=%0d, want a=%h b=%h op=%0d",
                         bus.alu_a, bus.alu_b, bus.alu_opcode, sb[$].a, sb[$].b, sb[$].op);
            end
        end
        if (rst_n && bus.done) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL done_flags: done pulse with nothing in flight");
            end else begin
                mon_e = sb.pop_front();
                model_r[mon_e.rd] = mon_e.res;
                if ({bus.flag_z, bus.flag_c} !== {mon_e.z, mon_e.c}) begin
                    n_err++;
                    $display("FAIL done_flags: got z=%b c=%b, want z=%b c=%b",
                             bus.flag_z, bus.flag_c, mon_e.z, mon_e.c);
                end
                $display("txn op=%0d rd=%0d a=%h b=%h res=%h z=%b c=%b",
                         mon_e.op, mon_e.rd, mon_e.a, mon_e.b, mon_e.res, mon_e.z, mon_e.c);
            end
        end
    end

    // Drives one instruction (call at a negedge) and pushes its prediction on accept.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb, input bit hold, output int waits);
        bit   rdy;
        bit   acc;
        exp_t e;
        bus.instr       = {op, rd, ra, rb, 4'($urandom)};
        bus.instr_valid = 1'b1;
        acc   = 1'b0;
        waits = 0;
        for (int k = 0; k < 16 && !acc; k++) begin
            rdy = bus.instr_ready;
            @(posedge clk);
            if (rdy) acc = 1'b1;
            else begin waits++; @(negedge clk); end
        end
        if (!hold) begin #1; bus.instr_valid = 1'b0; end
        n_vec++;
        if (!acc) begin
            n_err++;
            $display("FAIL accept: instr_ready=0 for 16 cycles, want 1");
        end else begin
            e = predict(op, rd, model_r[ra], model_r[rb]);
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input int start, output int lat);
        lat = start;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.done && lat < 12);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if ({bus.instr_ready, bus.done, bus.alu_a, bus.alu_b, bus.alu_opcode, bus.flag_z, bus.flag_c}
                !== {1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL reset_state: got rdy=%b done=%b a=%h b=%h op=%0d z=%b c=%b, want 1 0 00 00 0 0 0",
                         bus.instr_ready, bus.done, bus.alu_a, bus.alu_b, bus.alu_opcode, bus.flag_z, bus.flag_c);
            end
        end
    endtask

    task automatic test_chain();
        int w, lat;
        logic [2:0] ops [4] = '{OP_NOT, OP_ADD, OP_SUB, OP_AND};
        logic [2:0] rds [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic [2:0] ras [4] = '{3'd0, 3'd1, 3'd2, 3'd1};
        logic [2:0] rbs [4] = '{3'd0, 3'd1, 3'd2, 3'd2};
        logic [1:0] zc  [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], rds[i], ras[i], rbs[i], 1'b0, w);
            wait_done(0, lat);
            n_vec++;
            if (lat !== 4) begin
                n_err++;
                $display("FAIL chain_latency[%0d]: got %0d cycles, want 4", i, lat);
            end
            n_vec++;
            if ({bus.flag_z, bus.flag_c} !== zc[i]) begin
                n_err++;
                $display("FAIL chain_flags[%0d]: got zc=%b%b, want %b", i, bus.flag_z, bus.flag_c, zc[i]);
            end
        end
        issue(OP_OR, 3'd0, 3'd3, 3'd4, 1'b0, w);
        @(negedge clk);
        n_vec++;
        if ({bus.alu_a, bus.alu_b} !== 16'h00FE) begin
            n_err++;
            $display("FAIL chain_results: got R3=%h R4=%h, want 00 FE", bus.alu_a, bus.alu_b);
        end
        wait_done(1, lat);
    endtask

    task automatic test_back_to_back();
        int w, lat;
        issue(OP_SHL, 3'd5, 3'd1, 3'd1, 1'b1, w);
        #1;
        bus.instr = {OP_SHR, 3'd6, 3'd5, 3'd5, 4'hA};
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.instr_ready !== 1'b0) begin
                n_err++;
                $display("FAIL busy_ready[%0d]: got %b, want 0", i, bus.instr_ready);
            end
        end
        @(negedge clk);
        n_vec++;
        if ({bus.done, bus.instr_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL b2b_done_ready: got done=%b rdy=%b, want 1 1", bus.done, bus.instr_ready);
        end
        issue(OP_SHR, 3'd6, 3'd5, 3'd5, 1'b0, w);
        n_vec++;
        if (w !== 0) begin
            n_err++;
            $display("FAIL b2b_accept: got %0d wait cycles, want 0", w);
        end
        @(negedge clk);
        n_vec++;
        if (bus.alu_a !== 8'hFE) begin
            n_err++;
            $display("FAIL b2b_shl_result: got R5=%h, want FE", bus.alu_a);
        end
        wait_done(1, lat);
        n_vec++;
        if (lat !== 4) begin
            n_err++;
            $display("FAIL b2b_latency: got %0d, want 4", lat);
        end
        issue(OP_OR, 3'd0, 3'd6, 3'd6, 1'b0, w);
        @(negedge clk);
        n_vec++;
        if (bus.alu_a !== 8'h7F) begin
            n_err++;
            $display("FAIL b2b_shr_result: got R6=%h, want 7F", bus.alu_a);
        end
        wait_done(1, lat);
    endtask

    task automatic test_reset_mid();
        int w, lat;
        issue(OP_ADD, 3'd7, 3'd1, 3'd1, 1'b0, w);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.instr_ready, bus.done, bus.alu_a, bus.alu_b, bus.alu_opcode, bus.flag_z, bus.flag_c}
            !== {1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL midreset_state: got rdy=%b done=%b a=%h b=%h op=%0d z=%b c=%b, want 1 0 00 00 0 0 0",
                     bus.instr_ready, bus.done, bus.alu_a, bus.alu_b, bus.alu_opcode, bus.flag_z, bus.flag_c);
        end
        sb.delete();
        for (int i = 0; i < 8; i++) model_r[i] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) rst_n = 1'b1;
            n_vec++;
            if (bus.done !== 1'b0) begin
                n_err++;
                $display("FAIL midreset_done[%0d]: got %b, want 0", i, bus.done);
            end
        end
        issue(OP_OR, 3'd0, 3'd7, 3'd1, 1'b0, w);
        @(negedge clk);
        n_vec++;
        if ({bus.alu_a, bus.alu_b} !== 16'h0000) begin
            n_err++;
            $display("FAIL midreset_regs: got R7=%h R1=%h, want 00 00", bus.alu_a, bus.alu_b);
        end
        wait_done(1, lat);
    endtask

    task automatic test_rd_eq_ra();
        int w, lat;
        issue(OP_NOT, 3'd1, 3'd0, 3'd0, 1'b0, w);
        wait_done(0, lat);
        issue(OP_ADD, 3'd1, 3'd1, 3'd1, 1'b0, w);
        wait_done(0, lat);
        n_vec++;
        if ({lat, bus.flag_z, bus.flag_c} !== {32'd4, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL alias_add: got lat=%0d z=%b c=%b, want 4 0 1", lat, bus.flag_z, bus.flag_c);
        end
`ifdef ALU_SEQ_DBG_EN
        dbg_addr = 3'd1;
        #1;
        n_vec++;
        if (dbg_data !== 8'hFE) begin
            n_err++;
            $display("FAIL dbg_read: got %h, want FE", dbg_data);
        end
`endif
        issue(OP_OR, 3'd2, 3'd1, 3'd1, 1'b0, w);
        @(negedge clk);
        n_vec++;
        if (bus.alu_a !== 8'hFE) begin
            n_err++;
            $display("FAIL alias_result: got R1=%h, want FE", bus.alu_a);
        end
        wait_done(1, lat);
        n_vec++;
        if (bus.flag_c !== 1'b0) begin
            n_err++;
            $display("FAIL logic_clears_carry: got %b, want 0", bus.flag_c);
        end
    endtask

    task automatic test_random();
        int w, lat;
        for (int i = 0; i < 16; i++) begin
            issue(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'b0, w);
            wait_done(0, lat);
            n_vec++;
            if (lat !== 4) begin
                n_err++;
                $display("FAIL random_latency[%0d]: got %0d, want 4", i, lat);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;
        for (int i = 0; i < 8; i++) model_r[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_chain();
        test_back_to_back();
        test_reset_mid();
        test_rd_eq_ra();
        test_random();
        repeat (2) @(negedge clk);
        n_vec++;
        if (sb.size() !== 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
